// File: rtl/multi_timer.sv
// Multi-channel programmable up-counter timer on the 2 kHz game tick.
// Optional per-channel pause input is enabled with the MULTI_TIMER_PAUSE_EN macro.
module multi_timer #(
    parameter int WIDTH        = 12,
    parameter int CHANNELS     = 4,
    parameter int TERM_DEFAULT = 3999,
    parameter int LCW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_2K,
    input  logic                      i_ResetN,
    input  logic [CHANNELS-1:0]       i_Start,
    input  logic [CHANNELS-1:0]       i_Clear,
    input  logic [CHANNELS-1:0]       i_AutoReload,
`ifdef MULTI_TIMER_PAUSE_EN
    input  logic [CHANNELS-1:0]       i_Pause,
`endif
    input  logic                      i_Load,
    input  logic [LCW-1:0]            i_LoadCh,
    input  logic [WIDTH-1:0]          i_LoadVal,
    output logic [CHANNELS*WIDTH-1:0] o_Count,
    output logic [CHANNELS-1:0]       o_Tick,
    output logic [CHANNELS-1:0]       o_Done,
    output logic                      o_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(TERM_DEFAULT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [CHANNELS-1:0] run_vec;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // Load-channel values with no matching channel simply never hit.
            localparam logic [LCW-1:0] CH_IDX = LCW'(gi);

            state_t           state_reg, state_next;
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] term_reg, term_next;
            logic             tick_reg, tick_next;
            logic             done_reg, done_next;
            logic             load_hit;
            logic             paused;

            assign load_hit = i_Load && (i_LoadCh == CH_IDX);

`ifdef MULTI_TIMER_PAUSE_EN
            assign paused = i_Pause[gi];
`else
            assign paused = 1'b0;
`endif

            always_ff @(posedge clk_2K or negedge i_ResetN) begin
                if (!i_ResetN) begin
                    state_reg <= ST_IDLE;
                    count_reg <= '0;
                    term_reg  <= TERM_RST;
                    tick_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    term_reg  <= term_next;
                    tick_reg  <= tick_next;
                    done_reg  <= done_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                tick_next  = 1'b0;
                done_next  = done_reg;
                // The step below always compares against the old term_reg.
                term_next  = load_hit ? i_LoadVal : term_reg;

                if (i_Clear[gi]) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                    done_next  = 1'b0;
                end else if (i_Start[gi]) begin
                    state_next = ST_RUN;
                    count_next = '0;
                    done_next  = 1'b0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            count_next = '0;
                        end
                        ST_RUN: begin
                            if (!paused) begin
                                if (count_reg < term_reg) begin
                                    count_next = count_reg + ONE;
                                end else begin
                                    tick_next = 1'b1;
                                    if (i_AutoReload[gi]) begin
                                        count_next = '0;
                                    end else begin
                                        state_next = ST_DONE;
                                        count_next = term_reg;
                                        done_next  = 1'b1;
                                    end
                                end
                            end
                        end
                        ST_DONE: begin
                            done_next = 1'b1;
                        end
                        default: begin
                            state_next = ST_IDLE;
                            count_next = '0;
                            done_next  = 1'b0;
                        end
                    endcase
                end
            end

            assign o_Count[gi*WIDTH +: WIDTH] = count_reg;
            assign o_Tick[gi]                 = tick_reg;
            assign o_Done[gi]                 = done_reg;
            assign run_vec[gi]                = (state_reg == ST_RUN);
        end
    endgenerate

    assign o_Busy = |run_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (default parameters).
// Covers reset, one-shot, auto-reload, collisions, terminal 0 and optional pause.
module tb_multi_timer;

    logic        clk_2K = 1'b0;
    logic        i_ResetN;
    logic [3:0]  i_Start;
    logic [3:0]  i_Clear;
    logic [3:0]  i_AutoReload;
`ifdef MULTI_TIMER_PAUSE_EN
    logic [3:0]  i_Pause;
`endif
    logic        i_Load;
    logic [1:0]  i_LoadCh;
    logic [11:0] i_LoadVal;
    logic [47:0] o_Count;
    logic [3:0]  o_Tick;
    logic [3:0]  o_Done;
    logic        o_Busy;

    int n_cmp = 0;
    int n_err = 0;

    multi_timer dut (
        .clk_2K      (clk_2K),
        .i_ResetN    (i_ResetN),
        .i_Start     (i_Start),
        .i_Clear     (i_Clear),
        .i_AutoReload(i_AutoReload),
`ifdef MULTI_TIMER_PAUSE_EN
        .i_Pause     (i_Pause),
`endif
        .i_Load      (i_Load),
        .i_LoadCh    (i_LoadCh),
        .i_LoadVal   (i_LoadVal),
        .o_Count     (o_Count),
        .o_Tick      (o_Tick),
        .o_Done      (o_Done),
        .o_Busy      (o_Busy)
    );

    always #5 clk_2K = ~clk_2K;

    task automatic step();
        @(posedge clk_2K);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] cnt(input int ch);
        return o_Count[ch*12 +: 12];
    endfunction

    initial begin
        i_ResetN     = 1'b0;
        i_Start      = '0;
        i_Clear      = '0;
        i_AutoReload = '0;
`ifdef MULTI_TIMER_PAUSE_EN
        i_Pause      = '0;
`endif
        i_Load       = 1'b0;
        i_LoadCh     = '0;
        i_LoadVal    = '0;

        // Reset held for 3 clocks
        step(); step(); step();
        chk("rst_count", o_Count, 0);
        chk("rst_done",  o_Done, 0);
        chk("rst_tick",  o_Tick, 0);
        chk("rst_busy",  o_Busy, 0);
        i_ResetN = 1'b1;
        step();
        chk("idle_count", o_Count, 0);

        // ch0 with default terminal 3999, one-shot
        i_Start = 4'b0001;
        step();
        i_Start = '0;
        chk("ch0_start_cnt",  cnt(0), 0);
        chk("ch0_start_busy", o_Busy, 1);
        for (int k = 1; k <= 3999; k++) step();
        chk("ch0_3999_cnt",  cnt(0), 3999);
        chk("ch0_3999_tick", o_Tick[0], 0);
        step();
        chk("ch0_tick",      o_Tick[0], 1);
        chk("ch0_done",      o_Done[0], 1);
        chk("ch0_done_cnt",  cnt(0), 3999);
        step();
        chk("ch0_tick_off",  o_Tick[0], 0);
        chk("ch0_done_hold", o_Done[0], 1);
        i_Clear = 4'b0001;
        step();
        i_Clear = '0;
        chk("ch0_clr_cnt",  cnt(0), 0);
        chk("ch0_clr_done", o_Done[0], 0);
        chk("ch0_clr_busy", o_Busy, 0);

        // ch1 one-shot, terminal 5
        i_Load = 1'b1; i_LoadCh = 2'd1; i_LoadVal = 12'd5;
        step();
        i_Load = 1'b0;
        i_Start = 4'b0010;
        step();
        i_Start = '0;
        chk("os_cnt0", cnt(1), 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("os_cnt", cnt(1), k);
            chk("os_tick_lo", o_Tick[1], 0);
        end
        step();
        chk("os_tick", o_Tick[1], 1);
        chk("os_done", o_Done[1], 1);
        chk("os_cnt_term", cnt(1), 5);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("os_hold_cnt",  cnt(1), 5);
            chk("os_hold_tick", o_Tick[1], 0);
            chk("os_hold_done", o_Done[1], 1);
        end
        chk("os_busy", o_Busy, 0);

        // ch2 auto-reload, terminal 3: count 0,1,2,3 repeating, tick on wrap
        i_Load = 1'b1; i_LoadCh = 2'd2; i_LoadVal = 12'd3;
        i_AutoReload = 4'b0100;
        step();
        i_Load = 1'b0;
        i_Start = 4'b0100;
        step();
        i_Start = '0;
        chk("ar_cnt0", cnt(2), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("ar_cnt",  cnt(2), k % 4);
            chk("ar_tick", o_Tick[2], (k % 4 == 0) ? 1 : 0);
            chk("ar_done", o_Done[2], 0);
        end
        i_Clear = 4'b0100;
        step();
        i_Clear = '0;
        chk("ar_clr_busy", o_Busy, 0);

        // Collisions on ch0 (terminal still 3999, one-shot)
        i_Start = 4'b0001;
        step();
        i_Start = '0;
        step(); step(); step();
        chk("col_cnt3", cnt(0), 3);
        i_Start = 4'b0001; i_Clear = 4'b0001;
        step();
        i_Start = '0; i_Clear = '0;
        chk("col_clrstart_cnt",  cnt(0), 0);
        chk("col_clrstart_busy", o_Busy, 0);
        step();
        chk("col_idle_hold", cnt(0), 0);
        i_Start = 4'b0001;
        step();
        i_Start = '0;
        for (int k = 0; k < 7; k++) step();
        chk("col_cnt7", cnt(0), 7);
        i_Start = 4'b0001;
        step();
        i_Start = '0;
        chk("col_restart", cnt(0), 0);
        for (int k = 0; k < 7; k++) step();
        chk("col_cnt7b", cnt(0), 7);
        i_Load = 1'b1; i_LoadCh = 2'd0; i_LoadVal = 12'd2;
        step();
        i_Load = 1'b0;
        chk("col_load_cnt",  cnt(0), 8);
        chk("col_load_tick", o_Tick[0], 0);
        step();
        chk("col_term_tick", o_Tick[0], 1);
        chk("col_term_cnt",  cnt(0), 2);
        chk("col_term_done", o_Done[0], 1);
        step();
        chk("col_single_tick", o_Tick[0], 0);

        // ch3 terminal 0, auto-reload: tick every cycle from cycle 2
        i_Load = 1'b1; i_LoadCh = 2'd3; i_LoadVal = 12'd0;
        i_AutoReload = 4'b1000;
        i_Start = 4'b1000;
        step();
        i_Load = 1'b0; i_Start = '0;
        chk("t0_c1_cnt",  cnt(3), 0);
        chk("t0_c1_tick", o_Tick[3], 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t0_ar_tick", o_Tick[3], 1);
            chk("t0_ar_cnt",  cnt(3), 0);
            chk("t0_ar_done", o_Done[3], 0);
        end
        // one-shot variant
        i_AutoReload = '0;
        i_Start = 4'b1000;
        step();
        i_Start = '0;
        chk("t0_os_c1_tick", o_Tick[3], 0);
        step();
        chk("t0_os_tick", o_Tick[3], 1);
        chk("t0_os_done", o_Done[3], 1);
        step();
        chk("t0_os_tick_off", o_Tick[3], 0);
        chk("t0_os_busy",     o_Busy, 0);

        // Load and Start on the same channel in the same cycle
        i_Load = 1'b1; i_LoadCh = 2'd1; i_LoadVal = 12'd2;
        i_Start = 4'b0010;
        step();
        i_Load = 1'b0; i_Start = '0;
        chk("ls_cnt0", cnt(1), 0);
        chk("ls_done_clr", o_Done[1], 0);
        step(); step();
        chk("ls_cnt2", cnt(1), 2);
        step();
        chk("ls_tick", o_Tick[1], 1);
        chk("ls_done", o_Done[1], 1);

`ifdef MULTI_TIMER_PAUSE_EN
        // Pause ch0 at count 10 for 50 clocks
        i_Load = 1'b1; i_LoadCh = 2'd0; i_LoadVal = 12'd3999;
        i_Start = 4'b0001;
        step();
        i_Load = 1'b0; i_Start = '0;
        for (int k = 0; k < 10; k++) step();
        chk("pz_cnt10", cnt(0), 10);
        i_Pause = 4'b0001;
        for (int k = 0; k < 50; k++) begin
            step();
            chk("pz_hold", cnt(0), 10);
            chk("pz_tick", o_Tick[0], 0);
            chk("pz_busy", o_Busy, 1);
        end
        i_Pause = '0;
        step();
        chk("pz_resume", cnt(0), 11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
